// File: rtl/logisim_tick_source.sv
// Tick (clock-enable) strobe generator: free-runs at divider+1 cycles per tick or single-steps while halted.
// run/step pass a 2-flop synchroniser and are acted on at the 3rd edge; all outputs are flop-driven.
module logisim_tick_source #(
  parameter int nrOfBits  = 16,
  parameter int countBits = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic [nrOfBits-1:0]  divider,
  output logic                 tick,
  output logic                 slowClock,
  output logic                 running,
  output logic [countBits-1:0] tickCount
);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 run_meta_q, run_s_q;
  logic                 step_meta_q, step_s_q, step_dly_q;
  logic                 step_pulse;
  logic [nrOfBits-1:0]  counter_q, counter_d;
  logic                 tick_q, tick_d;
  logic                 slow_q, slow_d;
  logic [countBits-1:0] count_q, count_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_meta_q  <= 1'b0;
      run_s_q     <= 1'b0;
      step_meta_q <= 1'b0;
      step_s_q    <= 1'b0;
      step_dly_q  <= 1'b0;
    end else begin
      run_meta_q  <= run;
      run_s_q     <= run_meta_q;
      step_meta_q <= step;
      step_s_q    <= step_meta_q;
      step_dly_q  <= step_s_q;
    end
  end

  assign step_pulse = step_s_q & ~step_dly_q;

  // Counter defaults to 0 so HALT/STEP hold it cleared and a RUN exit drops the partial period.
  always_comb begin
    state_d   = state_q;
    counter_d = '0;
    tick_d    = 1'b0;
    case (state_q)
      HALT: begin
        if (run_s_q) begin
          state_d = RUN;
        end else if (step_pulse) begin
          state_d = STEP;
          tick_d  = 1'b1;
        end
      end
      STEP: begin
        state_d = HALT;
      end
      RUN: begin
        if (!run_s_q) begin
          state_d = HALT;
        end else if (counter_q >= divider) begin
          tick_d = 1'b1;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
    slow_d  = slow_q ^ tick_d;
    count_d = tick_d ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= HALT;
      counter_q <= '0;
      tick_q    <= 1'b0;
      slow_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      tick_q    <= tick_d;
      slow_q    <= slow_d;
      count_q   <= count_d;
    end
  end

  assign tick      = tick_q;
  assign slowClock = slow_q;
  assign running   = (state_q == RUN);
  assign tickCount = count_q;

endmodule

// File: tb/tb_logisim_tick_source.sv
// Bench for logisim_tick_source: directed scenarios with literal expectations, then randomized run/step/divider
// traffic checked every cycle against a behavioural model of the tick rules.
module tb_logisim_tick_source;
  localparam int NB = 16;
  localparam int CB = 32;
  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic [NB-1:0] divider = '0;
  logic          tick, slowClock, running;
  logic [CB-1:0] tickCount;

  int n_checks = 0;
  int n_fail = 0;

  logisim_tick_source #(.nrOfBits(NB), .countBits(CB)) dut (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .step     (step),
    .divider  (divider),
    .tick     (tick),
    .slowClock(slowClock),
    .running  (running),
    .tickCount(tickCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Inputs are seen by the control logic two edges after they are sampled;
  // a step "press" is a 0->1 change between consecutive sampled values.
  typedef struct packed {
    int   mode;
    int   el;
    logic tk;
  } mstep_t;

  int          m_mode = M_HALT;
  int          elapsed = 0;     // edges since RUN entry or last tick
  bit          m_tick = 1'b0;
  bit          m_slow = 1'b0;
  int unsigned m_count = 0;
  bit          r1 = 1'b0, r2 = 1'b0;
  bit          s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  mstep_t      nxt;

  function automatic mstep_t model_next(int mode, int el, bit rs, bit sp, int div);
    mstep_t r;
    r.mode = mode;
    r.el   = el;
    r.tk   = 1'b0;
    if (mode == M_RUN) begin
      if (!rs) begin
        r.mode = M_HALT;
        r.el   = 0;
      end else if (el + 1 > div) begin
        r.tk = 1'b1;
        r.el = 0;
      end else begin
        r.el = el + 1;
      end
    end else if (mode == M_STEP) begin
      r.mode = M_HALT;
    end else if (rs) begin
      r.mode = M_RUN;
      r.el   = 0;
    end else if (sp) begin
      r.mode = M_STEP;
      r.tk   = 1'b1;
    end
    return r;
  endfunction

  always_comb nxt = model_next(m_mode, elapsed, r2, s2 & ~s3, int'(divider));

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode <= M_HALT; elapsed <= 0; m_tick <= 1'b0; m_slow <= 1'b0; m_count <= 0;
      r1 <= 1'b0; r2 <= 1'b0; s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
    end else begin
      m_mode  <= nxt.mode;
      elapsed <= nxt.el;
      m_tick  <= nxt.tk;
      m_slow  <= m_slow ^ nxt.tk;
      m_count <= m_count + 32'(nxt.tk);
      r1 <= run;  r2 <= r1;
      s1 <= step; s2 <= s1; s3 <= s2;
    end
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clock) begin
    chk("tick", tick, m_tick);
    chk("slowClock", slowClock, m_slow);
    chk("running", running, m_mode == M_RUN);
    chk("tickCount", tickCount, m_count);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    #1 reset = 1'b0;
    run = 1'b1;
    divider = NB'(4);
    for (int i = 0; i < 10; i++) begin
      step = ~step;
      cyc(1);
      chk("rst_tick", tick, 0);
      chk("rst_running", running, 0);
    end
    chk("rst_slow", slowClock, 0);
    chk("rst_count", tickCount, 0);
    run = 1'b0; step = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(5);

    // free-run, divider=4: entry at 3rd edge, then 50 RUN edges
    run = 1'b1;
    cyc(53);
    chk("free_count", tickCount, 10);
    chk("free_model_count", m_count, 10);
    chk("free_tick", tick, 1);
    chk("free_slow", slowClock, 0);
    chk("free_running", running, 1);

    // divider=0: tick every cycle
    divider = '0;
    cyc(20);
    chk("div0_count", tickCount, 30);
    chk("div0_tick", tick, 1);

    // two more ticks while run drop propagates, then halt
    run = 1'b0;
    cyc(5);
    chk("halt_running", running, 0);
    chk("halt_count", tickCount, 32);
    chk("halt_tick", tick, 0);

    // single-step: three long presses give three ticks
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; cyc(20);
      step = 1'b0; cyc(20);
    end
    chk("step_count", tickCount, 35);
    chk("step_model_count", m_count, 35);
    chk("step_running", running, 0);

    // lower divider mid-period: counter 60, divider 100 -> 10
    divider = NB'(100);
    run = 1'b1;
    cyc(63);
    divider = NB'(10);
    cyc(1);
    chk("lower_tick", tick, 1);
    chk("lower_count", tickCount, 36);
    cyc(10);
    chk("lower_gap", tick, 0);
    cyc(1);
    chk("lower_period", tick, 1);
    cyc(11);
    chk("lower_count2", tickCount, 38);

    // drop run mid-period: no tick, counter cleared (next period full length)
    cyc(4);
    run = 1'b0;
    cyc(5);
    chk("drop_running", running, 0);
    chk("drop_count", tickCount, 38);
    run = 1'b1;
    cyc(3);
    chk("reentry_running", running, 1);
    cyc(10);
    chk("reentry_gap", tick, 0);
    cyc(1);
    chk("reentry_tick", tick, 1);
    chk("reentry_count", tickCount, 39);

    // run and step edge together: RUN wins, no step tick
    run = 1'b0;
    cyc(6);
    run = 1'b1; step = 1'b1;
    cyc(3);
    chk("race_running", running, 1);
    chk("race_tick", tick, 0);
    cyc(2);
    chk("race_count", tickCount, 39);

    // asynchronous reset mid-RUN
    cyc(4);
    #1 reset = 1'b0;
    #1;
    chk("areset_tick", tick, 0);
    chk("areset_slow", slowClock, 0);
    chk("areset_running", running, 0);
    chk("areset_count", tickCount, 0);
    cyc(2);
    step = 1'b0;
    reset = 1'b1;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 7) == 0) step = ~step;
      if ($urandom_range(0, 59) == 0) begin
        if ($urandom_range(0, 3) == 0) divider = NB'($urandom_range(0, 40));
        else divider = NB'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 1499) == 0) begin
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
      end
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
